pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 87 ++++++++
 rtl/pipe_skid_slot.sv | 60 ++++++
 rtl/pipe_stage_reg.sv | 99 +++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register: payload
// widths, per-stage packed payload layouts and control-vector bit positions.
package pipe_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_CTRL_W = 8;

   localparam int XLEN     = 32;
   localparam int REG_ID_W = 5;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_JJAL     = 3;
   localparam int CTRL_JRJALR   = 4;
   localparam int CTRL_LBSB     = 5;
   localparam int CTRL_LHSH     = 6;
   localparam int CTRL_UNSIGNED = 7;

   typedef struct packed {
      logic [XLEN-1:0] pc_plus8;
      logic [XLEN-1:0] instr;
   } ifid_data_t;

   typedef struct packed {
      logic [XLEN-1:0]     pc_plus8;
      logic [XLEN-1:0]     rs_val;
      logic [XLEN-1:0]     rt_val;
      logic [XLEN-1:0]     imm;
      logic [REG_ID_W-1:0] rs;
      logic [REG_ID_W-1:0] rt;
      logic [REG_ID_W-1:0] rd;
   } idex_data_t;

   // Bit order mirrors the CTRL_* indices so the struct can overlay the raw vector.
   typedef struct packed {
      logic is_unsigned;
      logic lhsh;
      logic lbsb;
      logic jrjalr;
      logic jjal;
      logic memtoreg;
      logic memwrite;
      logic regwrite;
   } exmem_ctrl_t;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_dst;
      logic        branch;
      exmem_ctrl_t mem_ctrl;
   } idex_ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0]     pc_plus8;
      logic [XLEN-1:0]     alu_result;
      logic [XLEN-1:0]     store_data;
      logic [REG_ID_W-1:0] rd;
   } exmem_data_t;

   typedef struct packed {
      logic [XLEN-1:0]     pc_plus8;
      logic [XLEN-1:0]     alu_result;
      logic [XLEN-1:0]     load_data;
      logic [REG_ID_W-1:0] rd;
   } memwb_data_t;

   typedef struct packed {
      logic jjal;
      logic memtoreg;
      logic regwrite;
   } memwb_ctrl_t;

   localparam int IFID_DATA_W  = $bits(ifid_data_t);
   localparam int IDEX_DATA_W  = $bits(idex_data_t);
   localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
   localparam int EXMEM_DATA_W = $bits(exmem_data_t);
   localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
   localparam int MEMWB_DATA_W = $bits(memwb_data_t);
   localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);

   function automatic logic ctrl_is_mem_op(input logic [DEFAULT_CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMWRITE] | ctrl[CTRL_MEMTOREG];
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One registered pipeline entry with valid bit. Priority: rst > clear > load > drain;
// ctrl is forced to zero whenever the entry is empty.
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W              = DEFAULT_DATA_W,
   parameter int CTRL_W              = DEFAULT_CTRL_W,
   parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_r;
   logic [DATA_W-1:0] data_r;
   logic [CTRL_W-1:0] ctrl_r;

   // Entry state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_W{1'b0}};
         ctrl_r  <= {CTRL_W{1'b0}};
      end else if (clear) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
         if (CLEAR_DATA_ON_FLUSH) begin
            data_r <= {DATA_W{1'b0}};
         end else begin
            data_r <= data_r;
         end
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= load_data;
         ctrl_r  <= load_ctrl;
      end else if (drain) begin
         // Data is left in place; only the qualifying bits are dropped.
         valid_r <= 1'b0;
         data_r  <= data_r;
         ctrl_r  <= {CTRL_W{1'b0}};
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
         ctrl_r  <= ctrl_r;
      end
   end

   assign valid = valid_r;
   assign data  = data_r;
   assign ctrl  = ctrl_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush bubbles.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready comes from a flop.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W              = DEFAULT_DATA_W,
   parameter int CTRL_W              = DEFAULT_CTRL_W,
   parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic              accept_s;
   logic              out_load_s;
   logic              out_drain_s;
   logic [DATA_W-1:0] out_load_data_s;
   logic [CTRL_W-1:0] out_load_ctrl_s;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid_s;
   logic              skid_load_s;
   logic              skid_drain_s;
   logic [DATA_W-1:0] skid_data_s;
   logic [CTRL_W-1:0] skid_ctrl_s;

   // Handshake and steering: the skid always refills the output before new input.
   always_comb begin
      in_ready        = ~skid_valid_s;
      accept_s        = in_valid & ~skid_valid_s;
      skid_load_s     = accept_s & out_valid & ~out_ready;
      skid_drain_s    = skid_valid_s & out_ready;
      out_load_data_s = in_data;
      out_load_ctrl_s = in_ctrl;
      if (skid_drain_s) begin
         out_load_s      = 1'b1;
         out_load_data_s = skid_data_s;
         out_load_ctrl_s = skid_ctrl_s;
      end else begin
         out_load_s = accept_s & (~out_valid | out_ready);
      end
      out_drain_s = out_valid & out_ready & ~out_load_s;
   end

   pipe_skid_slot #(
      .DATA_W              (DATA_W),
      .CTRL_W              (CTRL_W),
      .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (skid_load_s),
      .drain     (skid_drain_s),
      .load_data (in_data),
      .load_ctrl (in_ctrl),
      .valid     (skid_valid_s),
      .data      (skid_data_s),
      .ctrl      (skid_ctrl_s)
   );
`else
   // Handshake: a consumed entry may be replaced in the same cycle.
   always_comb begin
      in_ready        = out_ready | ~out_valid;
      accept_s        = in_valid & in_ready;
      out_load_s      = accept_s;
      out_load_data_s = in_data;
      out_load_ctrl_s = in_ctrl;
      out_drain_s     = out_valid & out_ready & ~accept_s;
   end
`endif

   pipe_skid_slot #(
      .DATA_W              (DATA_W),
      .CTRL_W              (CTRL_W),
      .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (out_load_s),
      .drain     (out_drain_s),
      .load_data (out_load_data_s),
      .load_ctrl (out_load_ctrl_s),
      .valid     (out_valid),
      .data      (out_data),
      .ctrl      (out_ctrl)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   localparam bit CLR = 1'b1;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [7:0]  in_ctrl, out_ctrl;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  c;
   } beat_t;

   beat_t       q[$];
   logic [31:0] stale = 32'h0;

   pipe_stage_reg #(
      .DATA_W              (32),
      .CTRL_W              (8),
      .CLEAR_DATA_ON_FLUSH (CLR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [31:0] d, input logic [7:0] c);
      rst       = r;
      flush     = f;
      in_valid  = iv;
      out_ready = ordy;
      in_data   = d;
      in_ctrl   = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: an ordered queue of at most CAP beats; head is what the output shows.
   initial begin
      logic        exp_rdy;
      logic        pop;
      logic        push;
      logic [31:0] exp_data;
      logic [7:0]  exp_ctrl;
      forever begin
         @(negedge clk);
         exp_rdy  = (q.size() < CAP) || (CAP == 1 && out_ready);
         exp_data = (q.size() > 0) ? q[0].d : stale;
         exp_ctrl = (q.size() > 0) ? q[0].c : 8'h00;
         if (chk_en) begin
            check("model out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("model out_data",  64'(out_data),  64'(exp_data));
            check("model out_ctrl",  64'(out_ctrl),  64'(exp_ctrl));
            check("model in_ready",  64'(in_ready),  64'(exp_rdy));
         end
         if (rst) begin
            q.delete();
            stale = 32'h0;
         end else if (flush) begin
            if (CLR) stale = 32'h0;
            else if (q.size() > 0) stale = q[0].d;
            q.delete();
         end else begin
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && exp_rdy;
            if (pop) begin
               stale = q[0].d;
               void'(q.pop_front());
            end
            if (push) q.push_back('{d: in_data, c: in_ctrl});
         end
      end
   end

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
      repeat (3) tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
      chk_en = 1'b1;
      check("reset out_valid", 64'(out_valid), 64'h0);
      check("reset out_ctrl",  64'(out_ctrl),  64'h0);
      check("reset out_data",  64'(out_data),  64'h0);
      #1 check("reset in_ready", 64'(in_ready), 64'h1);

      // Streaming 1..4 at full rate.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 32'(i), 8'(i));
         tick();
         check("stream out_data",  64'(out_data),  64'(i));
         check("stream out_valid", 64'(out_valid), 64'h1);
         check("stream in_ready",  64'(in_ready),  64'h1);
      end

      // Stall with 0x10 held, 0x14 offered.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 8'h21);
      tick();
      check("stall pre out_data", 64'(out_data), 64'h10);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h14, 8'h22);
      #1 check("stall first in_ready", 64'(in_ready), 64'(CAP == 2));
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall out_data",  64'(out_data),  64'h10);
         check("stall out_valid", 64'(out_valid), 64'h1);
         #1 check("stall in_ready", 64'(in_ready), 64'h0);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 8'h22);
      tick();
      check("release out_data", 64'(out_data), 64'h14);
      check("release out_ctrl", 64'(out_ctrl), 64'h22);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00);
      tick();
      check("drain out_valid", 64'(out_valid), 64'h0);
      check("drain out_ctrl",  64'(out_ctrl),  64'h0);
      check("drain out_data",  64'(out_data),  64'h14);

      // Flush with an incoming beat.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 8'h0C);
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h99, 8'hFF);
      #1 check("flush in_ready", 64'(in_ready), 64'h1);
      tick();
      check("flush out_valid", 64'(out_valid), 64'h0);
      check("flush out_ctrl",  64'(out_ctrl),  64'h0);
      check("flush out_data",  64'(out_data),  64'(CLR ? 32'h0 : 32'h55));

      // Flush during a stall, with the skid (if present) occupied.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 8'h5A);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 8'h5B);
      tick();
      check("stallflush pre data", 64'(out_data), 64'h33);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
      tick();
      check("stallflush out_valid", 64'(out_valid), 64'h0);
      check("stallflush out_ctrl",  64'(out_ctrl),  64'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00);
      tick();
      check("stallflush no skid beat", 64'(out_valid), 64'h0);

      // Reset mid-stream together with flush and an incoming beat.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 8'hA5);
      tick();
      check("prio pre out_ctrl", 64'(out_ctrl), 64'hA5);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h88, 8'hA5);
      tick();
      check("prio out_valid", 64'(out_valid), 64'h0);
      check("prio out_ctrl",  64'(out_ctrl),  64'h0);
      check("prio out_data",  64'(out_data),  64'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00);
      tick();
      check("prio no beat", 64'(out_valid), 64'h0);

      // Randomized traffic against the model.
      repeat (3000) begin
         drive(1'($urandom_range(0, 99) == 0),
               1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 9) < 7),
               32'($urandom),
               8'($urandom));
         tick();
      end

      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00);
      repeat (3) tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
